// File: rtl/jtdsp16_sio_rx_if.sv
// ============================================================================
//  Module      : jtdsp16_sio_rx_if
//  Description : Signal bundle between a jtdsp16 serial output port and its
//                receiver (jtdsp16_sio_rx).
//                  serial side : ock, sdo, sadd
//                  config      : cfg_len16, cfg_msb, addr_en, my_addr
//                  host side   : rx_data, rx_addr, rx_valid, rx_rd
//                  status      : ovr, sync_err, err_clr
//                master = driver of the serial lines / host (core + host),
//                slave  = the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jtdsp16_sio_rx_if;
    logic        ock;
    logic        sdo;
    logic        sadd;
    logic        cfg_len16;
    logic        cfg_msb;
    logic        addr_en;
    logic [7:0]  my_addr;
    logic [15:0] rx_data;
    logic [7:0]  rx_addr;
    logic        rx_valid;
    logic        rx_rd;
    logic        ovr;
    logic        sync_err;
    logic        err_clr;

    modport master (
        output ock, sdo, sadd, cfg_len16, cfg_msb, addr_en, my_addr,
               rx_rd, err_clr,
        input  rx_data, rx_addr, rx_valid, ovr, sync_err
    );

    modport slave (
        input  ock, sdo, sadd, cfg_len16, cfg_msb, addr_en, my_addr,
               rx_rd, err_clr,
        output rx_data, rx_addr, rx_valid, ovr, sync_err
    );
endinterface

`default_nettype wire

// File: rtl/jtdsp16_sio_rx.sv
// ============================================================================
//  Module      : jtdsp16_sio_rx
//  Description : Receiver for the jtdsp16 serial output port. Rebuilds 8- or
//                16-bit data words plus an 8-bit address from sdo/sadd/ock,
//                optionally filters on address and queues words in a FIFO.
//  Ports       : clk  - system clock (same as the core)
//                rst  - synchronous active-high reset
//                sio  - jtdsp16_sio_rx_if.slave (serial in, config, FIFO
//                       head/pop, sticky ovr/sync_err flags, err_clr)
//  Parameters  : DEPTH    - FIFO entries, power of two, 2..16
//                IDLE_CYC - clk cycles without an ock rise before a partial
//                           word is abandoned, 2..65535
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtdsp16_sio_rx #(
    parameter int DEPTH    = 4,
    parameter int IDLE_CYC = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    jtdsp16_sio_rx_if.slave   sio
);

    localparam int           c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [15:0]  c_IDLE     = 16'(IDLE_CYC);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              ock_r_q, ock_l_q, sdo_r_q, sadd_r_q;
    logic [3:0]        bit_cnt_q,  bit_cnt_d;
    logic              len16_q,    len16_d;
    logic              msb_q,      msb_d;
    logic [15:0]       data_q,     data_d;
    logic [7:0]        addr_q,     addr_d;
    logic [15:0]       idle_q,     idle_d;
    logic [c_AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [c_AW:0]     count_q,    count_d;
    logic              ovr_q,      ovr_d;
    logic              sync_err_q, sync_err_d;
    logic [15:0]       mem_data_q [DEPTH];
    logic [7:0]        mem_addr_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic        w_edge, w_first, w_len16, w_msb, w_last;
    logic [15:0] w_base, w_shift, w_word;
    logic [7:0]  w_addr;
    logic        w_match, w_push_req, w_timeout;
    logic        w_full, w_pop, w_push, w_ovr_set;

    always_comb begin
        w_edge  = ock_r_q & ~ock_l_q;
        w_first = (bit_cnt_q == 4'd0);

        // The first edge of a word uses the live config; later edges use
        // the copy latched on that first edge.
        w_len16 = w_first ? sio.cfg_len16 : len16_q;
        w_msb   = w_first ? sio.cfg_msb   : msb_q;
        w_last  = w_len16 ? (bit_cnt_q == 4'd15) : (bit_cnt_q == 4'd7);

        // Starting each word from zero keeps the unused upper byte of an
        // 8-bit word clean in both bit orders.
        w_base  = w_first ? 16'h0000 : data_q;
        if (w_msb) begin
            w_shift = {w_base[14:0], sdo_r_q};
        end else begin
            w_shift            = w_base;
            w_shift[bit_cnt_q] = sdo_r_q;
        end
        w_word  = w_len16 ? w_shift : {8'h00, w_shift[7:0]};

        // Address bits arrive LSB-first on edges 0..7 only.
        w_addr  = bit_cnt_q[3] ? addr_q : {sadd_r_q, addr_q[7:1]};

        w_match    = ~sio.addr_en || (w_addr == sio.my_addr) || (w_addr == 8'hFF);
        w_push_req = w_edge & w_last & w_match;
        w_timeout  = ~w_edge && (idle_q == c_IDLE) && !w_first;

        w_full     = (count_q == c_FULL);
        w_pop      = sio.rx_rd & (count_q != '0);
        // A pop in the same cycle frees the slot a full FIFO needs.
        w_push     = w_push_req & (~w_full | w_pop);
        w_ovr_set  = w_push_req & w_full & ~w_pop;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        len16_d    = len16_q;
        msb_d      = msb_q;
        data_d     = data_q;
        addr_d     = addr_q;
        idle_d     = idle_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (w_edge) begin
            bit_cnt_d = w_last ? 4'd0 : bit_cnt_q + 4'd1;
            data_d    = w_shift;
            addr_d    = w_addr;
            idle_d    = 16'd0;
            if (w_first) begin
                len16_d = sio.cfg_len16;
                msb_d   = sio.cfg_msb;
            end
        end else if (w_timeout) begin
            bit_cnt_d = 4'd0;
            idle_d    = 16'd0;
        end else if (idle_q != c_IDLE) begin
            idle_d    = idle_q + 16'd1;
        end

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set wins over clear.
        ovr_d      = (ovr_q      & ~sio.err_clr) | w_ovr_set;
        sync_err_d = (sync_err_q & ~sio.err_clr) | w_timeout;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // ock_r/ock_l reset high so a line already high at reset exit
            // is not mistaken for a rising edge.
            ock_r_q    <= 1'b1;
            ock_l_q    <= 1'b1;
            sdo_r_q    <= 1'b0;
            sadd_r_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            len16_q    <= 1'b0;
            msb_q      <= 1'b0;
            data_q     <= 16'h0000;
            addr_q     <= 8'h00;
            idle_q     <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= 16'h0000;
                mem_addr_q[i] <= 8'h00;
            end
        end else begin
            ock_r_q    <= sio.ock;
            ock_l_q    <= ock_r_q;
            sdo_r_q    <= sio.sdo;
            sadd_r_q   <= sio.sadd;
            bit_cnt_q  <= bit_cnt_d;
            len16_q    <= len16_d;
            msb_q      <= msb_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            idle_q     <= idle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            sync_err_q <= sync_err_d;
            if (w_push) begin
                mem_data_q[wr_ptr_q] <= w_word;
                mem_addr_q[wr_ptr_q] <= w_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sio.rx_data  = mem_data_q[rd_ptr_q];
    assign sio.rx_addr  = mem_addr_q[rd_ptr_q];
    assign sio.rx_valid = (count_q != '0);
    assign sio.ovr      = ovr_q;
    assign sio.sync_err = sync_err_q;

endmodule

`default_nettype wire
